// File: rtl/counter_pkg.sv
// Shared types for the up/down counter family.
// Boundary mode selection is used by both the RTL and the testbench.
package counter_pkg;

  typedef enum logic {
    CNT_WRAP = 1'b0,
    CNT_SAT  = 1'b1
  } cnt_mode_e;

endpackage

// File: rtl/counter_next.sv
// Combinational next-count and boundary-event logic for updown_counter.
// Arithmetic is carried in WIDTH+1 bits so crossings are seen before truncation.
module counter_next
  import counter_pkg::*;
#(
  parameter int unsigned         WIDTH   = 8,
  parameter logic [WIDTH-1:0]    MAX_VAL = {WIDTH{1'b1}},
  parameter cnt_mode_e           MODE    = CNT_WRAP
) (
  input  logic [WIDTH-1:0] count,
  input  logic [WIDTH-1:0] step,
  input  logic             up,
  output logic [WIDTH-1:0] nxt_c,
  output logic             evt_c
);

  localparam logic [WIDTH:0] MAX_X = {1'b0, MAX_VAL};
  localparam logic [WIDTH:0] MOD_X = MAX_X + (WIDTH+1)'(1);

  logic [WIDTH:0] cnt_x;
  logic [WIDTH:0] stp_x;
  logic [WIDTH:0] sum_x;

  // Clamp the step to the modulus range so a single update wraps at most once.
  always_comb begin
    cnt_x = {1'b0, count};
    stp_x = (step > MAX_VAL) ? MAX_X : {1'b0, step};
    sum_x = cnt_x + stp_x;
  end

  always_comb begin
    nxt_c = count;
    evt_c = 1'b0;
    if (stp_x != '0) begin
      if (up) begin
        if (sum_x > MAX_X) begin
          evt_c = 1'b1;
          nxt_c = (MODE == CNT_WRAP) ? WIDTH'(sum_x - MOD_X) : MAX_VAL;
        end else begin
          nxt_c = WIDTH'(sum_x);
        end
      end else begin
        if (stp_x > cnt_x) begin
          evt_c = 1'b1;
          nxt_c = (MODE == CNT_WRAP) ? WIDTH'(cnt_x + MOD_X - stp_x) : '0;
        end else begin
          nxt_c = WIDTH'(cnt_x - stp_x);
        end
      end
    end
  end

endmodule

// File: rtl/updown_counter.sv
// Parametrised up/down counter with load, wrap/saturate, terminal-count pulse,
// sticky overflow and combinational compare match.
module updown_counter
  import counter_pkg::*;
#(
  parameter int unsigned      WIDTH   = 8,
  parameter logic [WIDTH-1:0] MAX_VAL = {WIDTH{1'b1}},
  parameter cnt_mode_e        MODE    = CNT_WRAP
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             up,
  input  logic [WIDTH-1:0] step,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic [WIDTH-1:0] cmp_val,
  input  logic             clr_ovf,
  output logic [WIDTH-1:0] count_out,
  output logic             tc,
  output logic             ovf,
  output logic             match
);

  logic [WIDTH-1:0] nxt_c;
  logic             evt_c;
  logic [WIDTH-1:0] load_clamp_c;
  logic             set_ovf_c;

  counter_next #(
    .WIDTH   (WIDTH),
    .MAX_VAL (MAX_VAL),
    .MODE    (MODE)
  ) u_next (
    .count (count_out),
    .step  (step),
    .up    (up),
    .nxt_c (nxt_c),
    .evt_c (evt_c)
  );

  always_comb begin
    load_clamp_c = (load_val > MAX_VAL) ? MAX_VAL : load_val;
    set_ovf_c    = en & ~load & evt_c;
  end

  // Priority: reset > load > en; a set event outranks clr_ovf.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_out <= '0;
      tc        <= 1'b0;
      ovf       <= 1'b0;
    end else begin
      if (load) begin
        count_out <= load_clamp_c;
      end else if (en) begin
        count_out <= nxt_c;
      end
      tc  <= set_ovf_c;
      ovf <= set_ovf_c | (ovf & ~clr_ovf);
    end
  end

  assign match = (count_out == cmp_val);

endmodule

// File: tb/tb_updown_counter.sv
// Directed bench for updown_counter: WIDTH=4, MAX_VAL=9, one WRAP and one SAT
// instance sharing stimulus, checked against hand-computed values.
module tb_updown_counter;
  import counter_pkg::*;

  logic       clk = 1'b0;
  logic       reset, en, up, load, clr_ovf;
  logic [3:0] step, load_val, cmp_val;
  logic [3:0] cnt_w, cnt_s;
  logic       tc_w, tc_s, ovf_w, ovf_s, match_w, match_s;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  updown_counter #(.WIDTH(4), .MAX_VAL(4'd9), .MODE(CNT_WRAP)) dut_w (
    .clk(clk), .reset(reset), .en(en), .up(up), .step(step), .load(load),
    .load_val(load_val), .cmp_val(cmp_val), .clr_ovf(clr_ovf),
    .count_out(cnt_w), .tc(tc_w), .ovf(ovf_w), .match(match_w)
  );

  updown_counter #(.WIDTH(4), .MAX_VAL(4'd9), .MODE(CNT_SAT)) dut_s (
    .clk(clk), .reset(reset), .en(en), .up(up), .step(step), .load(load),
    .load_val(load_val), .cmp_val(cmp_val), .clr_ovf(clr_ovf),
    .count_out(cnt_s), .tc(tc_s), .ovf(ovf_s), .match(match_s)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; en = 1'b0; up = 1'b1; load = 1'b0; clr_ovf = 1'b0;
    step = 4'd0; load_val = 4'd0; cmp_val = 4'd4;

    // Reset state and combinational match.
    tick();
    chk("rst_cnt_w", 32'(cnt_w), 0);
    chk("rst_cnt_s", 32'(cnt_s), 0);
    chk("rst_tc_w", 32'(tc_w), 0);
    chk("rst_ovf_w", 32'(ovf_w), 0);
    chk("rst_ovf_s", 32'(ovf_s), 0);
    chk("rst_match_cmp4", 32'(match_w), 0);
    cmp_val = 4'd0;
    #1;
    chk("rst_match_cmp0", 32'(match_w), 1);
    cmp_val = 4'd4;

    // Up by 1 from 0: WRAP runs 1..9,0; SAT sticks at 9 with tc on the extra step.
    reset = 1'b0; en = 1'b1; up = 1'b1; step = 4'd1;
    for (int k = 1; k <= 10; k++) begin
      tick();
      chk("up1_cnt_w", 32'(cnt_w), (k == 10) ? 0 : k);
      chk("up1_tc_w", 32'(tc_w), (k == 10) ? 1 : 0);
      chk("up1_cnt_s", 32'(cnt_s), (k >= 9) ? 9 : k);
      chk("up1_tc_s", 32'(tc_s), (k == 10) ? 1 : 0);
    end
    chk("up1_ovf_w", 32'(ovf_w), 1);
    chk("up1_ovf_s", 32'(ovf_s), 1);

    // Down by 3: WRAP 0->7->4->1->8, SAT 9->6->3->0->0.
    up = 1'b0; step = 4'd3;
    tick();
    chk("dn3_cnt_w_1", 32'(cnt_w), 7);  chk("dn3_tc_w_1", 32'(tc_w), 1);
    chk("dn3_cnt_s_1", 32'(cnt_s), 6);  chk("dn3_tc_s_1", 32'(tc_s), 0);
    chk("dn3_match_w_1", 32'(match_w), 0);
    tick();
    chk("dn3_cnt_w_2", 32'(cnt_w), 4);  chk("dn3_tc_w_2", 32'(tc_w), 0);
    chk("dn3_match_w_2", 32'(match_w), 1);
    chk("dn3_match_s_2", 32'(match_s), 0);
    tick();
    chk("dn3_cnt_w_3", 32'(cnt_w), 1);  chk("dn3_tc_w_3", 32'(tc_w), 0);
    chk("dn3_cnt_s_3", 32'(cnt_s), 0);  chk("dn3_tc_s_3", 32'(tc_s), 0);
    chk("dn3_match_w_3", 32'(match_w), 0);
    tick();
    chk("dn3_cnt_w_4", 32'(cnt_w), 8);  chk("dn3_tc_w_4", 32'(tc_w), 1);
    chk("dn3_cnt_s_4", 32'(cnt_s), 0);  chk("dn3_tc_s_4", 32'(tc_s), 1);

    // Reset, then up by 4: SAT 4,8,9,9 (tc at rail); WRAP 4,8,2,6.
    reset = 1'b1;
    tick();
    chk("rst2_cnt_w", 32'(cnt_w), 0);
    chk("rst2_ovf_w", 32'(ovf_w), 0);
    reset = 1'b0; up = 1'b1; step = 4'd4;
    tick();
    chk("up4_cnt_s_1", 32'(cnt_s), 4);  chk("up4_tc_s_1", 32'(tc_s), 0);
    tick();
    chk("up4_cnt_s_2", 32'(cnt_s), 8);  chk("up4_cnt_w_2", 32'(cnt_w), 8);
    tick();
    chk("up4_cnt_s_3", 32'(cnt_s), 9);  chk("up4_tc_s_3", 32'(tc_s), 1);
    chk("up4_cnt_w_3", 32'(cnt_w), 2);  chk("up4_tc_w_3", 32'(tc_w), 1);
    tick();
    chk("up4_cnt_s_4", 32'(cnt_s), 9);  chk("up4_tc_s_4", 32'(tc_s), 1);
    chk("up4_cnt_w_4", 32'(cnt_w), 6);  chk("up4_tc_w_4", 32'(tc_w), 0);

    // Load 2 without enable, then down by 5: SAT -> 0 with tc, WRAP -> 7 with tc.
    en = 1'b0; load = 1'b1; load_val = 4'd2;
    tick();
    chk("ld2_cnt_w", 32'(cnt_w), 2);  chk("ld2_cnt_s", 32'(cnt_s), 2);
    chk("ld2_tc_s", 32'(tc_s), 0);
    load = 1'b0; en = 1'b1; up = 1'b0; step = 4'd5;
    tick();
    chk("dn5_cnt_s", 32'(cnt_s), 0);  chk("dn5_tc_s", 32'(tc_s), 1);
    chk("dn5_cnt_w", 32'(cnt_w), 7);  chk("dn5_tc_w", 32'(tc_w), 1);

    // Over-range load clamps; load beats enable.
    load = 1'b1; load_val = 4'd12; up = 1'b1; step = 4'd1;
    tick();
    chk("ld12_cnt_w", 32'(cnt_w), 9);  chk("ld12_cnt_s", 32'(cnt_s), 9);
    chk("ld12_tc_w", 32'(tc_w), 0);
    load_val = 4'd3;
    tick();
    chk("ld3_en_cnt_w", 32'(cnt_w), 3);
    chk("ld3_ovf_kept", 32'(ovf_w), 1);

    // Step 0 holds with no event.
    load = 1'b0; step = 4'd0;
    tick();
    chk("step0_cnt_w", 32'(cnt_w), 3);  chk("step0_tc_w", 32'(tc_w), 0);

    // clr_ovf with no event clears.
    en = 1'b0; clr_ovf = 1'b1;
    tick();
    chk("clr_ovf_w", 32'(ovf_w), 0);  chk("clr_ovf_s", 32'(ovf_s), 0);

    // clr_ovf coincident with a wrap event keeps ovf set; step=9 gives tc every cycle.
    en = 1'b1; up = 1'b1; step = 4'd9;
    tick();
    chk("clrevt_cnt_w", 32'(cnt_w), 2);  chk("clrevt_tc_w", 32'(tc_w), 1);
    chk("clrevt_ovf_w", 32'(ovf_w), 1);  chk("clrevt_ovf_s", 32'(ovf_s), 1);
    clr_ovf = 1'b0;
    tick();
    chk("hold_tc_cnt_w", 32'(cnt_w), 1);  chk("hold_tc_w", 32'(tc_w), 1);
    chk("hold_tc_s", 32'(tc_s), 1);

    // Reset mid-count with load and en active.
    load = 1'b1; load_val = 4'd6; en = 1'b0;
    tick();
    chk("mid_ld_cnt_w", 32'(cnt_w), 6);
    reset = 1'b1; en = 1'b1; load = 1'b1; load_val = 4'd5;
    tick();
    chk("mid_rst_cnt_w", 32'(cnt_w), 0);  chk("mid_rst_cnt_s", 32'(cnt_s), 0);
    chk("mid_rst_tc_w", 32'(tc_w), 0);
    chk("mid_rst_ovf_w", 32'(ovf_w), 0);  chk("mid_rst_ovf_s", 32'(ovf_s), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
